// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if -- bundle of the request, push and status signals of
// fifo_wr_arbiter.
//
// Optional build macro: FIFO_WR_ARB_TAG_EN.
// - When it is defined, the push word carries the granted requester index in its MSBs.
// - This changes FIFO_W here and in the arbiter.
//
// Signals:
//   req_vld       per-requester write valid        (requesters -> arbiter)
//   req_data      packed payloads, i at [i*DATA_SIZE +: DATA_SIZE]
//   req_rdy       per-requester accept, one-hot or zero (arbiter -> requesters)
//   fifo_in_vld   registered push strobe            (arbiter -> FIFO)
//   fifo_in_data  registered push word              (arbiter -> FIFO)
//   fifo_pop      one entry left the FIFO           (FIFO side -> arbiter)
//   occ_cnt       reserved-entry count (staged + resident)
//   grant_id      requester whose data is on fifo_in_data
//   err_underflow sticky pop-while-empty flag
//
// Modports:
//   slave   the arbiter's view
//   master  the environment's view
interface fifo_wr_arbiter_if #(
  parameter int REQ_NUM   = 4,
  parameter int DATA_SIZE = 32,
  parameter int ENT_NUM   = 4
);
  localparam int REQ_IDX_W = $clog2(REQ_NUM);
  localparam int OCC_W     = $clog2(ENT_NUM + 1);
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int FIFO_W    = DATA_SIZE + REQ_IDX_W;
`else
  localparam int FIFO_W    = DATA_SIZE;
`endif

  logic [REQ_NUM-1:0]           req_vld;
  logic [REQ_NUM*DATA_SIZE-1:0] req_data;
  logic [REQ_NUM-1:0]           req_rdy;
  logic                         fifo_in_vld;
  logic [FIFO_W-1:0]            fifo_in_data;
  logic                         fifo_pop;
  logic [OCC_W-1:0]             occ_cnt;
  logic [REQ_IDX_W-1:0]         grant_id;
  logic                         err_underflow;

  modport slave (
    input  req_vld, req_data, fifo_pop,
    output req_rdy, fifo_in_vld, fifo_in_data, occ_cnt, grant_id, err_underflow
  );

  modport master (
    output req_vld, req_data, fifo_pop,
    input  req_rdy, fifo_in_vld, fifo_in_data, occ_cnt, grant_id, err_underflow
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter -- round-robin arbiter that funnels REQ_NUM write requesters
// into one downstream one-in-one-out FIFO of ENT_NUM entries.
//
// Operation:
// - The block keeps a reservation count of entries that are either staged in
//   the push register or resident in the FIFO.
// - It only grants while that count is below ENT_NUM, so the FIFO can never
//   overflow.
// - A grant is registered onto fifo_in_* one cycle later.
//
// Optional build macro: FIFO_WR_ARB_TAG_EN.
// - When it is defined, fifo_in_data = {grant index, payload}.
// - Otherwise, fifo_in_data is just the payload.
//
// Ports:
//   clk  rising-edge clock for all state
//   rst  synchronous active-high reset
//   bus  fifo_wr_arbiter_if.slave (request/push/status signals)
module fifo_wr_arbiter #(
  parameter int REQ_NUM   = 4,
  parameter int DATA_SIZE = 32,
  parameter int ENT_NUM   = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int REQ_IDX_W = $clog2(REQ_NUM);
  localparam int OCC_W     = $clog2(ENT_NUM + 1);
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int FIFO_W    = DATA_SIZE + REQ_IDX_W;
`else
  localparam int FIFO_W    = DATA_SIZE;
`endif

  logic [REQ_NUM-1:0]   ptr_reg, ptr_next;
  logic [OCC_W-1:0]     occ_reg, occ_next;
  logic                 push_vld_reg;
  logic [FIFO_W-1:0]    push_data_reg, push_data_next;
  logic [REQ_IDX_W-1:0] grant_id_reg, grant_id_next;
  logic                 err_reg;

  logic [DATA_SIZE-1:0] data_arr [REQ_NUM];
  logic [REQ_NUM-1:0]   hi_vld, cand, grant_oh;
  logic [REQ_IDX_W-1:0] sel_idx;
  logic [DATA_SIZE-1:0] sel_data;
  logic                 space;
  logic                 accept;
  logic                 pop_eff;

  genvar gi;
  generate
    for (gi = 0; gi < REQ_NUM; gi++) begin : g_unpack
      assign data_arr[gi] = bus.req_data[gi*DATA_SIZE +: DATA_SIZE];
    end
  endgenerate

  // Pending pops free an entry only on the next cycle.
  // A full count therefore blocks grants even if a pop is happening right now.
  assign space = (occ_reg < OCC_W'(ENT_NUM));

  // Round-robin selection with a one-hot pointer:
  // - ~(ptr-1) masks the requesters at or above the pointer.
  // - If none of them is requesting, the search wraps to the full vector.
  // - x & -x then isolates the lowest set bit.
  assign hi_vld   = bus.req_vld & ~(ptr_reg - REQ_NUM'(1));
  assign cand     = (|hi_vld) ? hi_vld : bus.req_vld;
  assign grant_oh = cand & (~cand + REQ_NUM'(1));

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant_oh[i]) sel_idx = REQ_IDX_W'(i);
    end
  end

  assign sel_data    = data_arr[sel_idx];
  assign bus.req_rdy = (space && !rst) ? grant_oh : '0;
  assign accept      = |(bus.req_vld & bus.req_rdy);

  // A pop at zero occupancy is a protocol error.
  // Such a pop is flagged but does not move the count.
  assign pop_eff = bus.fifo_pop && (occ_reg != '0);

  always_comb begin
    occ_next       = occ_reg;
    ptr_next       = ptr_reg;
    push_data_next = push_data_reg;
    grant_id_next  = grant_id_reg;
    if (accept && !pop_eff) occ_next = occ_reg + OCC_W'(1);
    else if (!accept && pop_eff) occ_next = occ_reg - OCC_W'(1);
    if (accept) begin
      // The pointer moves to the requester just after the winner.
      ptr_next      = {grant_oh[REQ_NUM-2:0], grant_oh[REQ_NUM-1]};
      grant_id_next = sel_idx;
`ifdef FIFO_WR_ARB_TAG_EN
      push_data_next = {sel_idx, sel_data};
`else
      push_data_next = sel_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= REQ_NUM'(1);
      occ_reg       <= '0;
      push_vld_reg  <= 1'b0;
      push_data_reg <= '0;
      grant_id_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      ptr_reg       <= ptr_next;
      occ_reg       <= occ_next;
      push_vld_reg  <= accept;
      push_data_reg <= push_data_next;
      grant_id_reg  <= grant_id_next;
      if (bus.fifo_pop && (occ_reg == '0)) err_reg <= 1'b1;
    end
  end

  assign bus.fifo_in_vld   = push_vld_reg;
  assign bus.fifo_in_data  = push_data_reg;
  assign bus.occ_cnt       = occ_reg;
  assign bus.grant_id      = grant_id_reg;
  assign bus.err_underflow = err_reg;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter -- scoreboard bench for fifo_wr_arbiter.
//
// Stimulus process:
// - Drives inputs on the falling edge.
// - Checks the combinational req_rdy against a reference model.
// - Pushes the expected post-edge state and push words into queues.
//
// Monitor process:
// - Pops and compares those queues just after each rising edge.
//
// Stimulus sequence:
// - Directed cases first, then randomized traffic with occasional resets.
module tb_fifo_wr_arbiter;
  localparam int N         = 4;
  localparam int D         = 32;
  localparam int E         = 4;
  localparam int REQ_IDX_W = $clog2(N);
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int FIFO_W    = D + REQ_IDX_W;
`else
  localparam int FIFO_W    = D;
`endif

  typedef struct {
    bit                vld;
    int                occ;
    bit                err;
    int                grant;
    logic [FIFO_W-1:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rec_t              state_q[$];
  logic [FIFO_W-1:0] data_q[$];

  // Reference model state
  int                m_occ   = 0;
  int                m_ptr   = 0;
  bit                m_err   = 1'b0;
  int                m_grant = 0;
  logic [FIFO_W-1:0] m_data  = '0;

  fifo_wr_arbiter_if #(.REQ_NUM(N), .DATA_SIZE(D), .ENT_NUM(E)) bus ();

  fifo_wr_arbiter #(.REQ_NUM(N), .DATA_SIZE(D), .ENT_NUM(E)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // First requester with valid set, scanning upward from the pointer with wrap.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic step(input logic r, input logic [N-1:0] v,
                      input logic [N*D-1:0] d, input logic p);
    int   g;
    rec_t rec;
    bit   pop_eff;
    @(negedge clk);
    rst          = r;
    bus.req_vld  = v;
    bus.req_data = d;
    bus.fifo_pop = p;
    #1;
    g = -1;
    if (!r && m_occ < E) g = rr_pick(v, m_ptr);
    chk("req_rdy", 64'(bus.req_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
    if (r) begin
      m_occ   = 0;
      m_ptr   = 0;
      m_err   = 1'b0;
      m_grant = 0;
      m_data  = '0;
    end else begin
      pop_eff = p && (m_occ > 0);
      if (p && m_occ == 0) m_err = 1'b1;
      if (g >= 0) begin
        m_grant = g;
`ifdef FIFO_WR_ARB_TAG_EN
        m_data = {REQ_IDX_W'(g), d[g*D +: D]};
`else
        m_data = d[g*D +: D];
`endif
        data_q.push_back(m_data);
        m_ptr = (g + 1) % N;
      end
      m_occ = m_occ + ((g >= 0) ? 1 : 0) - (pop_eff ? 1 : 0);
    end
    rec.vld   = !r && (g >= 0);
    rec.occ   = m_occ;
    rec.err   = m_err;
    rec.grant = m_grant;
    rec.data  = m_data;
    state_q.push_back(rec);
  endtask

  function automatic logic [N*D-1:0] one_word(input int i, input logic [D-1:0] w);
    logic [N*D-1:0] d;
    d = '0;
    d[i*D +: D] = w;
    return d;
  endfunction

  function automatic logic [N*D-1:0] rand_words();
    logic [N*D-1:0] d;
    for (int i = 0; i < N; i++) d[i*D +: D] = D'($urandom);
    return d;
  endfunction

  // Monitor: compares the registered outputs just after each rising edge.
  initial begin
    rec_t              rec;
    logic [FIFO_W-1:0] exp_w;
    forever begin
      @(posedge clk);
      #1;
      if (state_q.size() > 0) begin
        rec = state_q.pop_front();
        chk("fifo_in_vld", 64'(bus.fifo_in_vld), 64'(rec.vld));
        chk("occ_cnt", 64'(bus.occ_cnt), 64'(rec.occ));
        chk("err_underflow", 64'(bus.err_underflow), 64'(rec.err));
        chk("grant_id", 64'(bus.grant_id), 64'(rec.grant));
        chk("held_data", 64'(bus.fifo_in_data), 64'(rec.data));
        if (bus.fifo_in_vld) begin
          if (data_q.size() > 0) begin
            exp_w = data_q.pop_front();
            chk("push_data", 64'(bus.fifo_in_data), 64'(exp_w));
            $display("push grant=%0d data=%0h occ=%0d", bus.grant_id, bus.fifo_in_data, bus.occ_cnt);
          end else begin
            chk("unexpected_push", 64'(bus.fifo_in_vld), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    bus.req_vld  = '0;
    bus.req_data = '0;
    bus.fifo_pop = 1'b0;

    // Reset, with pop and valids asserted that must be ignored.
    step(1'b1, '1, rand_words(), 1'b1);
    step(1'b1, '0, '0, 1'b0);

    // Fairness: four back-to-back grants 0,1,2,3, then full.
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, rand_words(), 1'b0);

    // Full with pop: no grant this cycle; grant next cycle without pop.
    step(1'b0, 4'b0100, rand_words(), 1'b1);
    step(1'b0, 4'b0100, rand_words(), 1'b0);
    step(1'b0, 4'b0000, '0, 1'b0);

    // Drain, then underflow; the flag must stick through later traffic.
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, 4'b0011, rand_words(), 1'b1);
    step(1'b0, '0, '0, 1'b1);

    // Pointer wrap: grant 3 alone, then 1001 must pick 0.
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 4'b1000, rand_words(), 1'b0);
    step(1'b0, 4'b1001, rand_words(), 1'b0);

    // Latency: requester 1 with a known word appears one cycle later.
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 4'b0010, one_word(1, 32'hA5A5_0001), 1'b0);
    step(1'b0, '0, '0, 1'b0);

    // Reset mid-burst: staged push is discarded and the pointer returns to 0.
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 4'b0100, rand_words(), 1'b0);
    step(1'b0, 4'b1000, rand_words(), 1'b0);
    step(1'b0, 4'b0010, rand_words(), 1'b0);
    step(1'b1, 4'b1111, rand_words(), 1'b0);
    step(1'b0, 4'b1111, rand_words(), 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) == 0), N'($urandom), rand_words(),
           ($urandom_range(99) < 45));
    end
    step(1'b0, '0, '0, 1'b0);

    guard = 0;
    while (state_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    chk("state_q_drained", 64'(state_q.size()), 64'd0);
    chk("data_q_drained", 64'(data_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter REQ_NUM, default 4: number of write requesters, 2..8.
REQ-002 The block SHALL have parameter DATA_SIZE, default 32: payload width per requester.
REQ-003 The block SHALL have parameter ENT_NUM, default 4: entry count of the downstream one-in-one-out FIFO.
REQ-004 The block SHALL have derived widths REQ_IDX_W = $clog2(REQ_NUM) and OCC_W = $clog2(ENT_NUM+1).
REQ-005 The block SHALL have port clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port req_vld, input, REQ_NUM: per-requester write valid.
REQ-008 The block SHALL have port req_data, input, REQ_NUM*DATA_SIZE: payloads, with requester i at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-009 The block SHALL have port req_rdy, output, REQ_NUM: per-requester accept; a transfer SHALL occur when req_vld[i] & req_rdy[i].
REQ-010 The block SHALL have port fifo_in_vld, output, 1: registered push strobe to the FIFO in_vld.
REQ-011 The block SHALL have port fifo_in_data, output, FIFO_W: registered push data, with FIFO_W defined per REQ-029/030.
REQ-012 The block SHALL have port fifo_pop, input, 1: FIFO out_vld & pick_rdy (one entry leaves).
REQ-013 The block SHALL have port occ_cnt, output, OCC_W: reserved-entry count.
REQ-014 The block SHALL have port grant_id, output, REQ_IDX_W: index of the requester whose data is on fifo_in_data.
REQ-015 The block SHALL have port err_underflow, output, 1: sticky pop-while-empty flag.

Function
REQ-016 The block SHALL deem space available when occ_cnt < ENT_NUM; when occ_cnt == ENT_NUM, no accept SHALL occur, even with fifo_pop in the same cycle.
REQ-017 The block SHALL use round-robin arbitration: a one-hot priority pointer selects the first requester with req_vld set, searching upward from the pointer with wrap.
REQ-018 req_rdy SHALL be combinational: at most one bit is set, only for the selected requester, and only when space is available.
REQ-019 On an accept from requester g, the priority pointer SHALL move to (g+1) mod REQ_NUM on the next cycle; with no accept, the pointer SHALL hold.
REQ-020 On an accept, the block SHALL register fifo_in_vld=1, fifo_in_data and grant_id=g, so push latency is exactly 1 cycle; otherwise fifo_in_vld SHALL be 0 next cycle and data and grant_id SHALL hold.
REQ-021 occ_cnt_nxt SHALL equal occ_cnt + accept - fifo_pop, and SHALL count both staged and FIFO-resident entries.
REQ-022 Simultaneous accept and fifo_pop SHALL leave occ_cnt unchanged.
REQ-023 fifo_pop with occ_cnt == 0 SHALL hold occ_cnt at 0 (no wrap) and SHALL set err_underflow, which stays set until rst.
REQ-024 Back-to-back accepts SHALL be allowed on every cycle while space remains, giving one push per cycle.
REQ-025 A requester's req_data SHALL be stable while req_vld is set and req_rdy is low; this is a requester obligation and the block SHALL NOT check it.

Reset
REQ-026 While rst is high at a clock edge, the block SHALL set occ_cnt=0, fifo_in_vld=0, fifo_in_data=0, grant_id=0, err_underflow=0, and the priority pointer to requester 0.
REQ-027 During rst, req_rdy SHALL be forced to 0, and req_vld and fifo_pop SHALL be ignored.
REQ-028 A reset asserted mid-operation SHALL discard any staged push; the FIFO SHALL be reset in the same cycle by the integrator.

Configuration
REQ-029 When FIFO_WR_ARB_TAG_EN is defined, FIFO_W SHALL be DATA_SIZE+REQ_IDX_W and fifo_in_data SHALL be {g, req_data[g]}, with the tag in the MSBs.
REQ-030 When FIFO_WR_ARB_TAG_EN is undefined, FIFO_W SHALL be DATA_SIZE and fifo_in_data SHALL be req_data[g]; grant_id SHALL be present in both builds.

Verification
REQ-031 Bench case, fairness: after reset, with req_vld=4'b1111 held, never pop, and ENT_NUM=4, accepts SHALL go 0,1,2,3; then req_rdy=0 and occ_cnt=4.
REQ-032 Bench case, full with pop: at occ_cnt=4, req_vld[2]=1 and fifo_pop=1 in one cycle, there SHALL be no accept and occ_cnt=3; the next cycle req_rdy[2]=1 and occ_cnt stays 3 only if pop is repeated, otherwise it becomes 4.
REQ-033 Bench case, pointer wrap: a single accept from requester 3 (REQ_NUM=4), then req_vld=4'b1001, SHALL grant 0 next.
REQ-034 Bench case, latency: req_vld[1]=1 with data 32'hA5A5_0001 at cycle t SHALL give fifo_in_vld=1, fifo_in_data=32'hA5A5_0001 (TAG build: {2'd1, 32'hA5A5_0001}) and grant_id=1 at t+1.
REQ-035 Bench case, underflow: fifo_pop=1 at occ_cnt=0 SHALL keep occ_cnt=0 and set err_underflow=1, which stays set across later traffic until rst.
REQ-036 Bench case, reset mid-burst: rst=1 for one cycle at occ_cnt=3 with a staged push SHALL give fifo_in_vld=0, occ_cnt=0 and pointer=0 the next cycle.
